req_credits_wr_mc: RTL and testbench

// - Multi-channel, parametrised write-request credit gate. Holds each channel's write request until that channel has buffered enough data beats.
// - Arbitrates eligible channels round-robin onto a single registered m_req.
// - Sits between the per-region/per-stream write request queues and the shared write DMA/network request path, so one stalled channel cannot block the others.

---
 rtl/req_credits_wr_mc_pkg.sv | 39 +++
 rtl/req_credits_rr_arb.sv | 44 ++++
 rtl/req_credits_wr_mc.sv | 171 +++++++++++++++++
 tb/tb_req_credits_wr_mc.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/req_credits_wr_mc_pkg.sv
// ============================================================================
// Module  : req_credits_wr_mc_pkg
// Brief   : Shared types, constants and the beat-count helper for the
//           write-request credit gate and its read-side successor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package req_credits_wr_mc_pkg;

    localparam int AXI_DATA_BITS   = 512;
    localparam int BLEN_BITS       = 4;
    localparam int N_CRED_CHAN_MAX = 16;
    localparam int LEN_BITS        = 28;
    localparam int VADDR_BITS      = 48;
    localparam int DEST_BITS       = 4;

    typedef struct packed {
        logic [VADDR_BITS-1:0] vaddr;
        logic [LEN_BITS-1:0]   len;
        logic [DEST_BITS-1:0]  dest;
    } req_t;

    typedef logic [BLEN_BITS:0] cred_cnt_t;

    // Beats needed to carry len bytes; one extra bit so lengths past the
    // buffer depth stay distinguishable from in-range ones.
    function automatic logic [LEN_BITS:0] beats_ceil(
        input logic [LEN_BITS-1:0] len,
        input int unsigned         BEAT_LOG_BITS
    );
        logic [LEN_BITS:0] w_round;
        w_round = (LEN_BITS+1)'((64'd1 << BEAT_LOG_BITS) - 64'd1);
        return ({1'b0, len} + w_round) >> BEAT_LOG_BITS;
    endfunction

endpackage

`default_nettype wire

// File: rtl/req_credits_rr_arb.sv
// ============================================================================
// Module  : req_credits_rr_arb
// Brief   : Combinational round-robin arbiter: one-hot grant searched from
//           i_rr_ptr upward with wrap, plus the pointer value to load next.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module req_credits_rr_arb #(
    parameter int N_CHAN   = 4,
    parameter int PTR_BITS = 2
) (
    input  logic [N_CHAN-1:0]   i_req,
    input  logic [PTR_BITS-1:0] i_rr_ptr,
    output logic [N_CHAN-1:0]   o_grant,
    output logic                o_any,
    output logic [PTR_BITS-1:0] o_rr_ptr_next
);

    logic w_found;

    always_comb begin
        o_grant       = '0;
        o_rr_ptr_next = i_rr_ptr;
        w_found       = 1'b0;
        for (int i = 0; i < N_CHAN; i++) begin
            int                  w_pos;
            logic [PTR_BITS-1:0] w_idx;
            w_pos = int'(i_rr_ptr) + i;
            if (w_pos >= N_CHAN) w_pos = w_pos - N_CHAN;
            w_idx = PTR_BITS'(w_pos);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_rr_ptr_next  = (w_pos == N_CHAN-1) ? '0 : PTR_BITS'(w_pos + 1);
            end
        end
    end

    assign o_any = w_found;

endmodule

`default_nettype wire

// File: rtl/req_credits_wr_mc.sv
// ============================================================================
// Module  : req_credits_wr_mc
// Brief   : Multi-channel write-request credit gate. Each channel's request
//           waits for enough buffered beats, then eligible channels are
//           arbitrated round-robin onto one registered output request.
//           Optional statistics counters under REQ_CREDITS_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module req_credits_wr_mc
    import req_credits_wr_mc_pkg::*;
#(
    parameter int N_CHAN    = 4,
    parameter int DATA_BITS = AXI_DATA_BITS,
    parameter int MAX_BEATS = 2**BLEN_BITS
) (
    input  logic                                    aclk,
    input  logic                                    areset,
    input  logic [N_CHAN-1:0]                       s_req_valid,
    output logic [N_CHAN-1:0]                       s_req_ready,
    input  req_t [N_CHAN-1:0]                       s_req_data,
    output logic                                    m_req_valid,
    input  logic                                    m_req_ready,
    output req_t                                    m_req_data,
    input  logic [N_CHAN-1:0]                       xfer,
    output logic [N_CHAN*$clog2(MAX_BEATS+1)-1:0]   cnt_out,
    output logic [N_CHAN-1:0]                       err
`ifdef REQ_CREDITS_STATS_EN
    ,
    output logic [N_CHAN*32-1:0]                    stall_cnt,
    output logic [N_CHAN*32-1:0]                    req_cnt
`endif
);

    localparam int BEAT_BYTES = DATA_BITS / 8;
    localparam int BEAT_LOG   = $clog2(BEAT_BYTES);
    localparam int CNT_BITS   = $clog2(MAX_BEATS + 1);
    localparam int PTR_BITS   = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

    localparam logic [LEN_BITS:0]   c_max_need = (LEN_BITS+1)'(MAX_BEATS);
    localparam logic [CNT_BITS:0]   c_max_sum  = (CNT_BITS+1)'(MAX_BEATS);
    localparam logic [CNT_BITS-1:0] c_max_cnt  = CNT_BITS'(MAX_BEATS);

    logic [N_CHAN-1:0]   w_elig;
    logic [N_CHAN-1:0]   w_drop;
    logic [N_CHAN-1:0]   w_arb_req;
    logic [N_CHAN-1:0]   w_grant;
    logic                w_any;
    logic [PTR_BITS-1:0] w_ptr_next;
    logic                w_out_ok;
    req_t                w_gnt_data;

    logic [N_CHAN-1:0]   r_xfer_q;
    logic [PTR_BITS-1:0] r_rr_ptr;
    logic                r_run;
    logic                r_m_valid;
    req_t                r_m_data;

    // r_run keeps every handshake closed while reset is held and for the
    // first edge after release, so release behaves synchronously.
    assign w_out_ok  = ~r_m_valid | m_req_ready;
    assign w_arb_req = w_elig & {N_CHAN{w_out_ok & r_run}};

    req_credits_rr_arb #(
        .N_CHAN   (N_CHAN),
        .PTR_BITS (PTR_BITS)
    ) u_arb (
        .i_req         (w_arb_req),
        .i_rr_ptr      (r_rr_ptr),
        .o_grant       (w_grant),
        .o_any         (w_any),
        .o_rr_ptr_next (w_ptr_next)
    );

    assign s_req_ready = w_grant | w_drop;

    for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
        logic [LEN_BITS:0]   w_need_full;
        logic [CNT_BITS:0]   w_need;
        logic [CNT_BITS:0]   w_take;
        logic [CNT_BITS:0]   w_sum;
        logic                w_oversize;
        logic [CNT_BITS-1:0] r_cnt;
        logic                r_err;

        assign w_need_full = beats_ceil(s_req_data[c].len, BEAT_LOG);
        assign w_oversize  = w_need_full > c_max_need;
        assign w_need      = w_need_full[CNT_BITS:0];
        assign w_drop[c]   = r_run & s_req_valid[c] & w_oversize;
        assign w_elig[c]   = s_req_valid[c] & ~w_oversize & ({1'b0, r_cnt} >= w_need);

        // A grant never exceeds the credit it was checked against, so the
        // subtraction cannot wrap; only the +1 side can overshoot.
        assign w_take = w_grant[c] ? w_need : '0;
        assign w_sum  = {1'b0, r_cnt} + (CNT_BITS+1)'(r_xfer_q[c]) - w_take;

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                r_cnt <= '0;
                r_err <= 1'b0;
            end else begin
                if (w_sum > c_max_sum) begin
                    r_cnt <= c_max_cnt;
                    r_err <= 1'b1;
                end else begin
                    r_cnt <= w_sum[CNT_BITS-1:0];
                end
                if (w_drop[c]) r_err <= 1'b1;
            end
        end

        assign cnt_out[c*CNT_BITS +: CNT_BITS] = r_cnt;
        assign err[c]                          = r_err;
    end

    always_comb begin
        w_gnt_data = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            if (w_grant[c]) w_gnt_data = s_req_data[c];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_xfer_q  <= '0;
            r_rr_ptr  <= '0;
            r_run     <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else begin
            r_xfer_q <= xfer;
            r_run    <= 1'b1;
            if (w_any) begin
                r_rr_ptr  <= w_ptr_next;
                r_m_valid <= 1'b1;
                r_m_data  <= w_gnt_data;
            end else if (m_req_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_req_valid = r_m_valid;
    assign m_req_data  = r_m_data;

`ifdef REQ_CREDITS_STATS_EN
    for (genvar c = 0; c < N_CHAN; c++) begin : g_stats
        logic [31:0] r_stall;
        logic [31:0] r_req;

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                r_stall <= '0;
                r_req   <= '0;
            end else begin
                if (s_req_valid[c] && !w_elig[c] && (r_stall != 32'hFFFF_FFFF))
                    r_stall <= r_stall + 32'd1;
                if (w_grant[c])
                    r_req <= r_req + 32'd1;
            end
        end

        assign stall_cnt[c*32 +: 32] = r_stall;
        assign req_cnt[c*32 +: 32]   = r_req;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_req_credits_wr_mc.sv
// ============================================================================
// Module  : tb_req_credits_wr_mc
// Brief   : Directed self-checking bench for req_credits_wr_mc (4 channels,
//           64-byte beats, 16-beat buffers).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_req_credits_wr_mc;
    import req_credits_wr_mc_pkg::*;

    localparam int N  = 4;
    localparam int CB = 5;

    logic              aclk;
    logic              areset;
    logic [N-1:0]      s_valid;
    logic [N-1:0]      s_ready;
    req_t [N-1:0]      s_data;
    logic              m_valid;
    logic              m_ready;
    req_t              m_data;
    logic [N-1:0]      xfer;
    logic [N*CB-1:0]   cnt_out;
    logic [N-1:0]      err;
`ifdef REQ_CREDITS_STATS_EN
    logic [N*32-1:0]   stall_cnt;
    logic [N*32-1:0]   req_cnt;
`endif

    int   errors = 0;
    int   checks = 0;
    int   left[N];
    int   m_log[$];
    req_t held;

    req_credits_wr_mc dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_req_valid (s_valid),
        .s_req_ready (s_ready),
        .s_req_data  (s_data),
        .m_req_valid (m_valid),
        .m_req_ready (m_ready),
        .m_req_data  (m_data),
        .xfer        (xfer),
        .cnt_out     (cnt_out),
        .err         (err)
`ifdef REQ_CREDITS_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .req_cnt     (req_cnt)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt_of(input int c);
        return int'(cnt_out[c*CB +: CB]);
    endfunction

    task automatic set_req(input int c, input int n, input logic [27:0] len);
        left[c]        = n;
        s_data[c].len  = len;
        s_data[c].dest = 4'(c);
        s_data[c].vaddr = 48'(c * 4096 + 32'(len));
        s_valid[c]     = (n > 0);
    endtask

    // One clock: sample handshakes before the edge, retire them after it.
    task automatic step();
        logic [N-1:0] hs;
        #1;
        hs = s_valid & s_ready;
        if (m_valid && m_ready) m_log.push_back(int'(m_data.dest));
        @(posedge aclk);
        #1;
        for (int c = 0; c < N; c++) begin
            if (hs[c]) left[c]--;
            s_valid[c] = (left[c] > 0);
        end
    endtask

    initial begin
        areset  = 1'b1;
        m_ready = 1'b1;
        xfer    = '0;
        s_valid = '0;
        s_data  = '0;
        for (int c = 0; c < N; c++) left[c] = 0;

        // Reset: even a zero-length request must not be accepted.
        set_req(3, 1, 28'd0);
        step(); step();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_cnt", cnt_out, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", s_ready, 0);
        set_req(3, 0, 28'd0);
        areset = 1'b0;
        step(); step();

        // Single channel: 4 beats, len=256.
        set_req(0, 1, 28'd256);
        repeat (4) begin xfer = 4'b0001; step(); end
        xfer = '0;
        chk("t1_cnt_before", cnt_of(0), 3);
        chk("t1_ready_wait", s_ready[0], 0);
        step();
        chk("t1_ready_grant", s_ready[0], 1);
        chk("t1_mvalid_early", m_valid, 0);
        step();
        chk("t1_mvalid", m_valid, 1);
        chk("t1_len", m_data.len, 256);
        chk("t1_cnt_after", cnt_of(0), 0);
        step();
        chk("t1_mvalid_drop", m_valid, 0);

        // Starvation: ch1 needs 8 with 7 credited; ch0/ch2 proceed.
        xfer = 4'b0111; step();
        xfer = 4'b0010; repeat (6) step();
        xfer = '0; step(); step();
        chk("t2_cnt1", cnt_of(1), 7);
        chk("t2_cnt0", cnt_of(0), 1);
        m_log.delete();
        set_req(1, 1, 28'd512);
        set_req(0, 1, 28'd64);
        set_req(2, 1, 28'd64);
        repeat (4) step();
        chk("t2_grants", m_log.size(), 2);
        if (m_log.size() == 2) begin
            chk("t2_first", m_log[0], 2);
            chk("t2_second", m_log[1], 0);
        end
        chk("t2_starved_ready", s_ready[1], 0);
        chk("t2_starved_cnt", cnt_of(1), 7);
        xfer = 4'b0010; step();
        xfer = '0; step();
        chk("t2_release", s_ready[1], 1);
        step();
        chk("t2_cnt1_zero", cnt_of(1), 0);
        step();
        chk("t2_last_grant", m_log.size() > 0 ? m_log[$] : -1, 1);

        // Round robin from a fresh pointer: 4 x len=64 on every channel.
        areset = 1'b1; step();
        areset = 1'b0; step(); step();
        xfer = 4'hF; repeat (8) step();
        xfer = '0; step(); step();
        chk("t3_cnt_all", cnt_out, {4{5'd8}});
        m_log.delete();
        for (int c = 0; c < N; c++) set_req(c, 4, 28'd64);
        repeat (16) step();
        chk("t3_cnt_left", cnt_out, {4{5'd4}});
        chk("t3_drained", s_valid, 0);
        step();
        chk("t3_count", m_log.size(), 16);
        for (int i = 0; i < m_log.size(); i++)
            chk($sformatf("t3_order%0d", i), m_log[i], i % 4);

        // Grant and registered xfer in the same cycle on ch2.
        set_req(2, 1, 28'd128);
        step(); step();
        chk("t4_cnt2", cnt_of(2), 2);
        xfer = 4'b0100; step();
        xfer = '0;
        set_req(2, 1, 28'd128);
        #1;
        chk("t4_ready", s_ready[2], 1);
        step();
        chk("t4_cnt_net", cnt_of(2), 1);
        step();

        // Boundaries: len=0, oversize drop, credit overflow.
        set_req(3, 1, 28'd0);
        #1;
        chk("t5_len0_ready", s_ready[3], 1);
        step();
        chk("t5_len0_mvalid", m_valid, 1);
        chk("t5_len0_cnt", cnt_of(3), 4);
        step();
        set_req(0, 1, 28'd1088);
        #1;
        chk("t5_over_ready", s_ready[0], 1);
        step();
        chk("t5_over_nomreq", m_valid, 0);
        chk("t5_over_err", err, 4'b0001);
        chk("t5_over_cnt", cnt_of(0), 4);
        xfer = 4'b1000; repeat (12) step();
        xfer = '0; step(); step();
        chk("t5_full_cnt", cnt_of(3), 16);
        chk("t5_full_noerr", err, 4'b0001);
        xfer = 4'b1000; step();
        xfer = '0; step(); step();
        chk("t5_sat_cnt", cnt_of(3), 16);
        chk("t5_sat_err", err, 4'b1001);

        // Backpressure, then asynchronous reset mid-stall.
        m_ready = 1'b0;
        set_req(1, 1, 28'd64);
        held = s_data[1];
        step();
        chk("t6_valid", m_valid, 1);
        set_req(2, 1, 28'd64);
        repeat (10) step();
        chk("t6_valid_held", m_valid, 1);
        chk("t6_vaddr", m_data.vaddr, held.vaddr);
        chk("t6_dest", m_data.dest, 1);
        chk("t6_ch2_blocked", s_ready[2], 0);
        #3 areset = 1'b1;
        #1;
        chk("t6_rst_mvalid", m_valid, 0);
        chk("t6_rst_cnt", cnt_out, 0);
        chk("t6_rst_err", err, 0);
        set_req(2, 0, 28'd0);
        step();
        areset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
